// File: rtl/seq_symbol_tx.sv
`default_nettype none
// ============================================================================
// Module   : seq_symbol_tx
// Brief    : Replays a programmed pattern of 2-bit symbols 'reps' times on a
//            registered en/x interface, honouring a downstream hold stall.
//            Optional macro SEQ_GEN_GAP_EN adds idle gap cycles between passes.
// Revision : 1.0 - initial release
// ============================================================================
module seq_symbol_tx #(
    parameter  int MAX_LEN = 8,
    parameter  int REP_W   = 4,
    parameter  int GAP_W   = 4,
    localparam int LEN_W   = $clog2(MAX_LEN + 1),
    localparam int IDX_W   = $clog2(MAX_LEN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2*MAX_LEN-1:0]   pat,
    input  logic [LEN_W-1:0]       len,
    input  logic [REP_W-1:0]       reps,
`ifdef SEQ_GEN_GAP_EN
    input  logic [GAP_W-1:0]       gap,
`endif
    input  logic                   hold,
    output logic                   en,
    output logic [1:0]             x,
    output logic [IDX_W-1:0]       idx,
    output logic                   busy,
    output logic                   done
);

    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);

    generate
        if (MAX_LEN < 2 || REP_W < 1 || GAP_W < 1) begin : g_bad_param
            $error("seq_symbol_tx: MAX_LEN must be >= 2, REP_W and GAP_W >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
`ifdef SEQ_GEN_GAP_EN
        ,
        S_GAP  = 2'd3
`endif
    } state_t;

    state_t                 r_state;
    logic [2*MAX_LEN-1:0]   r_pat;
    logic [LEN_W-1:0]       r_len;
    logic [REP_W-1:0]       r_reps;
    logic [IDX_W-1:0]       r_i;
    logic [REP_W-1:0]       r_pass;
    logic                   r_en;
    logic [1:0]             r_x;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_busy;
    logic                   r_done;
`ifdef SEQ_GEN_GAP_EN
    logic [GAP_W-1:0]       r_gap;
    logic [GAP_W-1:0]       r_gcnt;
`endif

    logic [LEN_W-1:0]       w_len_clamp;
    logic [REP_W-1:0]       w_reps_eff;
    logic                   w_last_sym;
    logic                   w_last_pass;
    logic [1:0]             w_sym;

    assign w_len_clamp = (len > c_max_len) ? c_max_len : len;
    assign w_reps_eff  = (reps == '0) ? REP_W'(1) : reps;
    assign w_last_sym  = (LEN_W'(r_i) == (r_len - LEN_W'(1)));
    assign w_last_pass = (r_pass == (r_reps - REP_W'(1)));
    assign w_sym       = r_pat[{r_i, 1'b0} +: 2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pat   <= '0;
            r_len   <= '0;
            r_reps  <= '0;
            r_i     <= '0;
            r_pass  <= '0;
            r_en    <= 1'b0;
            r_x     <= 2'd0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SEQ_GEN_GAP_EN
            r_gap   <= '0;
            r_gcnt  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_en   <= 1'b0;
                    r_done <= 1'b0;
                    // r_done still high here means this is the done cycle: ignore start
                    if (start && !r_done) begin
                        r_pat   <= pat;
                        r_len   <= w_len_clamp;
                        r_reps  <= w_reps_eff;
                        r_i     <= '0;
                        r_pass  <= '0;
                        r_busy  <= 1'b1;
`ifdef SEQ_GEN_GAP_EN
                        r_gap   <= gap;
`endif
                        r_state <= (w_len_clamp == '0) ? S_DONE : S_SEND;
                    end
                end
                S_SEND: begin
                    if (hold) begin
                        r_en <= 1'b0;
                    end else begin
                        r_en  <= 1'b1;
                        r_x   <= w_sym;
                        r_idx <= r_i;
                        if (w_last_sym) begin
                            r_i <= '0;
                            if (w_last_pass) begin
                                r_state <= S_DONE;
                            end else begin
                                r_pass <= r_pass + REP_W'(1);
`ifdef SEQ_GEN_GAP_EN
                                if (r_gap != '0) begin
                                    r_gcnt  <= r_gap;
                                    r_state <= S_GAP;
                                end
`endif
                            end
                        end else begin
                            r_i <= r_i + IDX_W'(1);
                        end
                    end
                end
`ifdef SEQ_GEN_GAP_EN
                S_GAP: begin
                    r_en   <= 1'b0;
                    r_gcnt <= r_gcnt - GAP_W'(1);
                    if (r_gcnt == GAP_W'(1)) begin
                        r_state <= S_SEND;
                    end
                end
`endif
                S_DONE: begin
                    r_en    <= 1'b0;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign en   = r_en;
    assign x    = r_x;
    assign idx  = r_idx;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_symbol_tx.sv
`default_nettype none
// Testbench for seq_symbol_tx: queue-based behavioural model checked every cycle,
// plus directed scenarios with literal expected symbol streams.
module tb_seq_symbol_tx;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        hold  = 1'b0;
    logic [15:0] pat   = '0;
    logic [3:0]  len   = '0;
    logic [3:0]  reps  = '0;
`ifdef SEQ_GEN_GAP_EN
    logic [3:0]  gap   = '0;
`endif
    logic        en;
    logic [1:0]  x;
    logic [2:0]  idx;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    seq_symbol_tx #(.MAX_LEN(8), .REP_W(4), .GAP_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .pat   (pat),
        .len   (len),
        .reps  (reps),
`ifdef SEQ_GEN_GAP_EN
        .gap   (gap),
`endif
        .hold  (hold),
        .en    (en),
        .x     (x),
        .idx   (idx),
        .busy  (busy),
        .done  (done)
    );

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the whole transmission is a list of symbol slots (-1 = gap bubble);
    // each non-held edge consumes one slot, an empty list means done next edge.
    int   q_sym[$];
    int   q_idx[$];
    int   phase = 0;
    int   e_en = 0, e_x = 0, e_idx = 0, e_busy = 0, e_done = 0;

    task automatic build_list();
        int n, r;
        n = (int'(len) > 8) ? 8 : int'(len);
        r = (reps == 0) ? 1 : int'(reps);
        q_sym.delete();
        q_idx.delete();
        for (int p = 0; p < r; p++) begin
            for (int i = 0; i < n; i++) begin
                q_sym.push_back(int'((pat >> (2 * i)) & 16'h3));
                q_idx.push_back(i);
            end
`ifdef SEQ_GEN_GAP_EN
            if (p < r - 1 && n > 0) begin
                for (int g = 0; g < int'(gap); g++) begin
                    q_sym.push_back(-1);
                    q_idx.push_back(0);
                end
            end
`endif
        end
    endtask

    task automatic model_step();
        int prev_done;
        if (rst) begin
            phase = 0; e_en = 0; e_x = 0; e_idx = 0; e_busy = 0; e_done = 0;
            q_sym.delete();
            q_idx.delete();
        end else begin
            prev_done = e_done;
            e_done = 0;
            e_en   = 0;
            if (phase == 0) begin
                if (start && prev_done == 0) begin
                    build_list();
                    e_busy = 1;
                    phase  = (q_sym.size() > 0) ? 1 : 2;
                end
            end else if (phase == 1) begin
                if (q_sym[0] < 0) begin
                    void'(q_sym.pop_front());
                    void'(q_idx.pop_front());
                end else if (!hold) begin
                    e_en  = 1;
                    e_x   = q_sym.pop_front();
                    e_idx = q_idx.pop_front();
                end
                if (q_sym.size() == 0) phase = 2;
            end else begin
                e_done = 1;
                e_busy = 0;
                phase  = 0;
            end
        end
    endtask

    int seen[$];
    int ndone = 0, n_en = 0, en_first = -1, en_last = -1, done_cyc = -1, cyc = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            model_step();
            chk("en",   en,   e_en);
            chk("x",    x,    e_x);
            chk("idx",  idx,  e_idx);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            if (en === 1'b1) begin
                seen.push_back(int'(x));
                n_en++;
                if (en_first < 0) en_first = cyc;
                en_last = cyc;
            end
            if (done === 1'b1) begin
                ndone++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        seen.delete();
        ndone = 0; n_en = 0; en_first = -1; en_last = -1; done_cyc = -1;
    endtask

    int start_cyc = 0;

    task automatic launch(input logic [15:0] p, input logic [3:0] l, input logic [3:0] r);
        @(negedge clk);
        pat = p; len = l; reps = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string name, input int limit);
        int k = 0;
        while (ndone == 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk(name, (ndone > 0) ? 1 : 0, 1);
        tick(2);
    endtask

    task automatic wait_en(input string name, input int target, input int limit);
        int k = 0;
        while (n_en < target && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk(name, (n_en >= target) ? 1 : 0, 1);
    endtask

    task automatic check_seq(input string name, input int exp[$]);
        chk({name, "_count"}, seen.size(), exp.size());
        for (int i = 0; i < exp.size() && i < seen.size(); i++) begin
            chk({name, "_sym"}, seen[i], exp[i]);
        end
    endtask

    initial begin
        int e[$];
        int k;

        // 1: reset for two cycles
        tick(2);
        chk("rst_en", en, 0);
        chk("rst_x", x, 0);
        chk("rst_idx", idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        tick(2);

        // 2: single pass of 0,1,2,3
        clear_log();
        launch(16'h00E4, 4'd4, 4'd1);
        chk("t2_busy_after_start", busy, 1);
        wait_done("t2_timeout", 40);
        e = '{0, 1, 2, 3};
        check_seq("t2", e);
        chk("t2_first_lat", en_first - start_cyc, 1);
        chk("t2_span", en_last - en_first + 1, 4);
        chk("t2_done_after_last", done_cyc - en_last, 1);
        chk("t2_ndone", ndone, 1);
        chk("t2_busy_end", busy, 0);

        // 3: two symbols, three back-to-back passes
        clear_log();
        launch(16'h000B, 4'd2, 4'd3);
        wait_done("t3_timeout", 40);
        e = '{3, 2, 3, 2, 3, 2};
        check_seq("t3", e);
        chk("t3_span", en_last - en_first + 1, 6);
        chk("t3_ndone", ndone, 1);

        // 4: hold for two cycles once x=1 is visible
        clear_log();
        launch(16'h00E4, 4'd4, 4'd1);
        k = 0;
        while (!(en === 1'b1 && x === 2'd1) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t4_reach_x1", (k < 20) ? 1 : 0, 1);
        hold = 1'b1;
        tick(2);
        chk("t4_held_x", x, 1);
        chk("t4_held_en", en, 0);
        hold = 1'b0;
        wait_done("t4_timeout", 40);
        e = '{0, 1, 2, 3};
        check_seq("t4", e);
        chk("t4_span", en_last - en_first + 1, 6);

        // 5a: len=0 finishes without any symbol
        clear_log();
        launch(16'h00E4, 4'd0, 4'd2);
        wait_done("t5a_timeout", 20);
        chk("t5a_no_en", n_en, 0);
        chk("t5a_lat", done_cyc - start_cyc, 1);

        // 5b: len beyond MAX_LEN clamps to eight symbols
        clear_log();
        launch(16'hD8E4, 4'd12, 4'd1);
        wait_done("t5b_timeout", 40);
        e = '{0, 1, 2, 3, 0, 2, 1, 3};
        check_seq("t5b", e);

        // reps=0 behaves as a single pass
        clear_log();
        launch(16'h00E4, 4'd2, 4'd0);
        wait_done("t5r_timeout", 40);
        e = '{0, 1};
        check_seq("t5r", e);

        // 5c: start mid-pass and in the done cycle are both ignored
        clear_log();
        launch(16'h00E4, 4'd4, 4'd2);
        wait_en("t5c_reach", 3, 20);
        pat = 16'hFFFF; len = 4'd1; reps = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("t5c_reach_done", (k < 40) ? 1 : 0, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tick(4);
        e = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_seq("t5c", e);
        chk("t5c_ndone", ndone, 1);
        chk("t5c_idle_busy", busy, 0);

        // 5d: reset mid-pass aborts with no done pulse
        clear_log();
        launch(16'h00E4, 4'd4, 4'd3);
        wait_en("t5d_reach", 2, 20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick(4);
        chk("t5d_ndone", ndone, 0);
        chk("t5d_busy", busy, 0);
        chk("t5d_x", x, 0);
        chk("t5d_idx", idx, 0);
        chk("t5d_count", seen.size(), 2);

`ifdef SEQ_GEN_GAP_EN
        // 6: three idle cycles between two passes
        clear_log();
        gap = 4'd3;
        launch(16'h000B, 4'd2, 4'd2);
        wait_done("t6_timeout", 40);
        e = '{3, 2, 3, 2};
        check_seq("t6", e);
        chk("t6_span", en_last - en_first + 1, 7);
        chk("t6_ndone", ndone, 1);
        gap = 4'd0;
`endif

        tick(2);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
